dm_bus_ctrl: RTL and testbench
==============================

DM_BUS_CTRL -- requirements
Module: dm_bus_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum bus wait cycles before a timeout error.
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port `mem_req`, input, 1 bit: the pipeline MEM stage has a load or store this cycle.
REQ-005 SHALL have port `mem_w`, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port `addr`, input, 32 bits: byte address from the EX/MEM register.
REQ-007 SHALL have port `wdata`, input, 32 bits: store data, right-justified.
REQ-008 SHALL have port `dm_type`, input, 3 bits: access size and signedness, shared encoding.
REQ-009 SHALL have port `rdata`, output, 32 bits: the extended load result for MEM/WB.
REQ-010 SHALL have port `stall`, output, 1 bit: freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
REQ-011 SHALL have port `err`, output, 1 bit: one-cycle pulse on a timeout or misaligned access.
REQ-012 SHALL have port `bus_req`, output, 1 bit: bus request.
REQ-013 SHALL have port `bus_we`, output, 1 bit: bus write enable.
REQ-014 SHALL have port `bus_addr`, output, 32 bits: word-aligned bus address ({addr[31:2],2'b00}).
REQ-015 SHALL have port `bus_wdata`, output, 32 bits: lane-replicated store data.
REQ-016 SHALL have port `bus_be`, output, 4 bits: byte enables.
REQ-017 SHALL have port `bus_ready`, input, 1 bit: the bus has completed the access (MIO_ready).
REQ-018 SHALL have port `bus_rdata`, input, 32 bits: raw word read from the bus.

Function
REQ-019 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-020 IDLE with mem_req=1 and the access accepted SHALL register bus_addr, bus_we, bus_be, bus_wdata and the lane/type, assert bus_req, and go to WAIT.
REQ-021 stall SHALL be combinationally 1 in IDLE while mem_req=1, and 1 throughout WAIT; it SHALL be 0 in DONE and in IDLE with mem_req=0.
REQ-022 WAIT with bus_ready=1 SHALL capture bus_rdata, deassert bus_req and go to DONE; minimum latency is therefore 2 cycles from request to the stall release.
REQ-023 DONE SHALL drive rdata from the captured word for one cycle, then return to IDLE; mem_req is ignored in DONE (the pipeline advances), so back-to-back accesses are spaced by at least 3 cycles.
REQ-024 Byte lanes: a byte uses lane addr[1:0]; a half uses lane addr[1]*2; bus_be = 0001<<lane for bytes, 0011<<lane for halves, 1111 for words.
REQ-025 bus_wdata SHALL replicate wdata[7:0] ×4 for a byte, wdata[15:0] ×2 for a half, and wdata unchanged for a word.
REQ-026 Loads SHALL shift the captured word right by lane×8, then sign- or zero-extend it according to dm_type.
REQ-027 rdata SHALL be 0 outside DONE.
REQ-028 A WAIT-cycle counter SHALL run from 0; when it reaches WAIT_MAX without bus_ready, the block SHALL pulse err, set rdata to 0, and go to DONE.
REQ-029 The counter SHALL clear on every entry to WAIT.
REQ-030 bus_ready seen in IDLE or DONE SHALL be ignored.
REQ-031 An unknown dm_type SHALL be treated as a word access.

Reset
REQ-032 On rst=0, the block SHALL immediately enter IDLE with bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, rdata=0, err=0, stall=0 and the counter at 0.
REQ-033 A reset during WAIT SHALL drop bus_req with no further handshake.
REQ-034 After rst rises, the first request SHALL be accepted on the first clock edge.

Configuration
REQ-035 The feature SHALL be controlled by the macro DM_MISALIGN_TRAP_EN.
REQ-036 With DM_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]≠0 SHALL issue no bus access; the block SHALL go IDLE→DONE, pulse err, and return rdata=0.
REQ-037 Without DM_MISALIGN_TRAP_EN, the block SHALL force the low address bits to alignment (half: addr[0]=0; word: addr[1:0]=00) and proceed normally with err never set by misalignment.

Structure
REQ-038 The shared package SHALL hold the dm_type encoding (DM_WORD=0, DM_HALF=1, DM_HALF_U=2, DM_BYTE=3, DM_BYTE_U=4) and the FSM state encoding.
REQ-039 The lane steering, bus_be and load extension logic SHALL be one combinational sub-module, dm_lane_align, used for both the store and load paths; the FSM and counter stay in dm_bus_ctrl.

Verification
REQ-040 Byte store: addr=0x1003, wdata=0x000000A5, type DM_BYTE, bus_ready on the 2nd WAIT cycle -> bus_addr=0x1000, bus_be=1000, bus_wdata=0xA5A5A5A5, stall high for 3 cycles.
REQ-041 Signed half load: addr=0x2002, bus_rdata=0x8001_1234, type DM_HALF -> rdata=0xFFFF8001; with DM_HALF_U -> rdata=0x00008001.
REQ-042 Timeout: WAIT_MAX=15 and bus_ready never asserted -> err pulses on the 15th WAIT cycle, rdata=0, and stall drops the following cycle.
REQ-043 Misaligned word: addr=0x3001 -> with the macro defined, err=1, bus_req stays 0, and latency is 1 cycle; without it, bus_addr=0x3000 and bus_be=1111.
REQ-044 Reset mid-WAIT: rst=0 on the 3rd WAIT cycle -> bus_req=0 and stall=0 asynchronously; a new request is accepted after release.
REQ-045 Back-to-back loads: two loads with immediate bus_ready -> each sees 1 WAIT cycle, and DONE separates them.

Source files
------------

// File: rtl/dm_bus_ctrl_pkg.sv
// Shared encodings for the data-memory bus controller: dm_type codes, FSM states,
// access-size decode and the registered lane/type record.
package dm_bus_ctrl_pkg;

    localparam logic [2:0] DM_WORD   = 3'd0;
    localparam logic [2:0] DM_HALF   = 3'd1;
    localparam logic [2:0] DM_HALF_U = 3'd2;
    localparam logic [2:0] DM_BYTE   = 3'd3;
    localparam logic [2:0] DM_BYTE_U = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } dm_size_e;

    typedef struct packed {
        logic [2:0] dm_type;
        logic [1:0] lane;
    } dm_acc_t;

    // Unknown dm_type codes fall back to a full-word access.
    function automatic dm_size_e size_of(input logic [2:0] t);
        case (t)
            DM_HALF, DM_HALF_U: return SZ_HALF;
            DM_BYTE, DM_BYTE_U: return SZ_BYTE;
            default:            return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] a);
        case (size_of(t))
            SZ_HALF: return a[0];
            SZ_WORD: return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_bus_ctrl_if.sv
// Pipeline-side and bus-side signals of dm_bus_ctrl; master is the controller's view,
// slave is the pipeline/bus environment's view.
interface dm_bus_ctrl_if;

    logic        mem_req;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_type;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        input  mem_req, mem_w, addr, wdata, dm_type, bus_ready, bus_rdata,
        output rdata, stall, err, bus_req, bus_we, bus_addr, bus_wdata, bus_be
    );

    modport slave (
        output mem_req, mem_w, addr, wdata, dm_type, bus_ready, bus_rdata,
        input  rdata, stall, err, bus_req, bus_we, bus_addr, bus_wdata, bus_be
    );

endinterface

// File: rtl/dm_bus_ctrl_lane_align.sv
// dm_lane_align: byte-lane steering for stores (lane, byte enables, replicated data)
// and right-shift plus sign/zero extension for loads.
module dm_lane_align
    import dm_bus_ctrl_pkg::*;
(
    input  logic [2:0]  i_st_type,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_wdata,
    output logic [1:0]  o_st_lane,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,

    input  logic [2:0]  i_ld_type,
    input  logic [1:0]  i_ld_lane,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_ld_shift;

    // Half accesses ignore addr[0], word accesses ignore addr[1:0]: alignment is forced here.
    always_comb begin
        o_st_lane  = 2'b00;
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_wdata;
        case (size_of(i_st_type))
            SZ_BYTE: begin
                o_st_lane  = i_st_addr_lo;
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {4{i_st_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_st_lane  = {i_st_addr_lo[1], 1'b0};
                o_st_be    = 4'b0011 << {i_st_addr_lo[1], 1'b0};
                o_st_wdata = {2{i_st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_ld_shift = i_ld_word >> {i_ld_lane, 3'b000};

    always_comb begin
        o_ld_data = w_ld_shift;
        case (i_ld_type)
            DM_BYTE:   o_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            DM_BYTE_U: o_ld_data = {24'h000000, w_ld_shift[7:0]};
            DM_HALF:   o_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            DM_HALF_U: o_ld_data = {16'h0000, w_ld_shift[15:0]};
            default:   o_ld_data = w_ld_shift;
        endcase
    end

endmodule

// File: rtl/dm_bus_ctrl.sv
// dm_bus_ctrl: stalls the pipeline MEM stage while a load/store runs on a ready-handshake bus.
// Optional trap on misaligned half/word accesses: define DM_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | no bus access; a mem_req is accepted (or trapped) this cycle
// WAIT  | bus_req held; waiting for bus_ready or the WAIT_MAX timeout
// DONE  | rdata valid for one cycle; pipeline advances, mem_req ignored
module dm_bus_ctrl
    import dm_bus_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    dm_bus_ctrl_if.master dm
);

    localparam int              CW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WAIT_MAX - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_bus_req;
    logic          r_bus_we;
    logic [31:0]   r_bus_addr;
    logic [31:0]   r_bus_wdata;
    logic [3:0]    r_bus_be;
    dm_acc_t       r_acc;
    logic [31:0]   r_rword;

    logic [1:0]    w_st_lane;
    logic [3:0]    w_st_be;
    logic [31:0]   w_st_wdata;
    logic [31:0]   w_ld_data;
    logic          w_trap;
    logic          w_timeout;

    dm_lane_align u_lane_align (
        .i_st_type    (dm.dm_type),
        .i_st_addr_lo (dm.addr[1:0]),
        .i_st_wdata   (dm.wdata),
        .o_st_lane    (w_st_lane),
        .o_st_be      (w_st_be),
        .o_st_wdata   (w_st_wdata),
        .i_ld_type    (r_acc.dm_type),
        .i_ld_lane    (r_acc.lane),
        .i_ld_word    (r_rword),
        .o_ld_data    (w_ld_data)
    );

`ifdef DM_MISALIGN_TRAP_EN
    assign w_trap = is_misaligned(dm.dm_type, dm.addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    // bus_ready wins over the timeout when both land on the last WAIT cycle.
    assign w_timeout = (r_state == ST_WAIT) && !dm.bus_ready && (r_cnt == CNT_LAST);

    // Gated by rst so a held mem_req cannot stall the pipeline during reset.
    assign dm.stall = rst && (((r_state == ST_IDLE) && dm.mem_req) || (r_state == ST_WAIT));
    assign dm.err   = rst && (((r_state == ST_IDLE) && dm.mem_req && w_trap) || w_timeout);
    assign dm.rdata = (r_state == ST_DONE) ? w_ld_data : 32'h0;

    assign dm.bus_req   = r_bus_req;
    assign dm.bus_we    = r_bus_we;
    assign dm.bus_addr  = r_bus_addr;
    assign dm.bus_wdata = r_bus_wdata;
    assign dm.bus_be    = r_bus_be;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_bus_be    <= 4'h0;
            r_acc       <= '0;
            r_rword     <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dm.mem_req) begin
                        if (w_trap) begin
                            r_rword <= 32'h0;
                            r_state <= ST_DONE;
                        end else begin
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= dm.mem_w;
                            r_bus_addr  <= {dm.addr[31:2], 2'b00};
                            r_bus_wdata <= w_st_wdata;
                            r_bus_be    <= w_st_be;
                            r_acc       <= '{dm_type: dm.dm_type, lane: w_st_lane};
                            r_cnt       <= '0;
                            r_state     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dm.bus_ready) begin
                        r_rword   <= dm.bus_rdata;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rword   <= 32'h0;
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Self-checking bench for dm_bus_ctrl: table of accesses with a scoreboard queue,
// plus hand-written reset-during-WAIT and idle bus_ready sequences.
module tb_dm_bus_ctrl;
    import dm_bus_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_bus_ctrl_if bif();

    dm_bus_ctrl #(.WAIT_MAX(15)) u_dut (
        .clk (clk),
        .rst (rst),
        .dm  (bif)
    );

    typedef struct {
        logic        mem_w;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        int          ready_at;
        logic [31:0] e_baddr;
        logic [3:0]  e_be;
        logic [31:0] e_bwdata;
        logic [31:0] e_rdata;
        int          e_stall;
        int          e_wait;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic w, input logic [2:0] t, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input int rdy,
                                input logic [31:0] ba, input logic [3:0] be,
                                input logic [31:0] bwd, input logic [31:0] erd,
                                input int est, input int ewt, input logic eer);
        vec_t v;
        v.mem_w = w;  v.typ = t;  v.addr = a;  v.wdata = wd;  v.brdata = rd;  v.ready_at = rdy;
        v.e_baddr = ba;  v.e_be = be;  v.e_bwdata = bwd;  v.e_rdata = erd;
        v.e_stall = est;  v.e_wait = ewt;  v.e_err = eer;
        return v;
    endfunction

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after the DONE cycle.
    task automatic run_access(input vec_t v, input int idx);
        vec_t        e;
        int          n_stall = 0;
        int          n_wait  = 0;
        int          n_err   = 0;
        int          err_cyc = -1;
        int          bad_rd  = 0;
        bit          done    = 1'b0;
        logic [31:0] cap_addr  = 32'h0;
        logic [31:0] cap_wdata = 32'h0;
        logic [3:0]  cap_be    = 4'h0;
        logic        cap_we    = 1'b0;
        logic        req_done  = 1'b0;
        logic [31:0] rd        = 32'h0;

        sb.push_back(v);
        bif.mem_req   = 1'b1;
        bif.mem_w     = v.mem_w;
        bif.addr      = v.addr;
        bif.wdata     = v.wdata;
        bif.dm_type   = v.typ;
        bif.bus_rdata = v.brdata;
        bif.bus_ready = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bif.bus_req) begin
                n_wait++;
                if (n_wait == 1) begin
                    cap_addr  = bif.bus_addr;
                    cap_wdata = bif.bus_wdata;
                    cap_be    = bif.bus_be;
                    cap_we    = bif.bus_we;
                end
                bif.bus_ready = (v.ready_at != 0) && (n_wait == v.ready_at);
            end else begin
                bif.bus_ready = 1'b0;
            end
            @(negedge clk);
            if (bif.err) begin
                n_err++;
                err_cyc = c;
            end
            if (bif.stall) begin
                n_stall++;
                if (bif.rdata !== 32'h0) bad_rd++;
            end else begin
                done     = 1'b1;
                rd       = bif.rdata;
                req_done = bif.bus_req;
            end
            @(posedge clk);
            #1;
        end
        bif.bus_ready = 1'b0;
        bif.mem_req   = 1'b0;

        e = sb.pop_front();
        chk($sformatf("v%0d completed", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d stall_cycles", idx), 32'(n_stall), 32'(e.e_stall));
        chk($sformatf("v%0d wait_cycles", idx), 32'(n_wait), 32'(e.e_wait));
        chk($sformatf("v%0d err_pulses", idx), 32'(n_err), 32'(e.e_err));
        chk($sformatf("v%0d rdata", idx), rd, e.e_rdata);
        chk($sformatf("v%0d rdata_zero_while_stalled", idx), 32'(bad_rd), 32'd0);
        chk($sformatf("v%0d bus_req_in_done", idx), 32'(req_done), 32'd0);
        if (e.e_err) chk($sformatf("v%0d err_cycle", idx), 32'(err_cyc), 32'(e.e_stall - 1));
        if (e.e_wait > 0) begin
            chk($sformatf("v%0d bus_addr", idx), cap_addr, e.e_baddr);
            chk($sformatf("v%0d bus_be", idx), 32'(cap_be), 32'(e.e_be));
            chk($sformatf("v%0d bus_wdata", idx), cap_wdata, e.e_bwdata);
            chk($sformatf("v%0d bus_we", idx), 32'(cap_we), 32'(e.mem_w));
        end
    endtask

    initial begin
        int bad;

        // w, type, addr, wdata, bus_rdata, ready_at | bus_addr, be, bus_wdata, rdata, stall, wait, err
        vecs.push_back(mk(1, DM_BYTE,   32'h0000_1003, 32'h0000_00A5, 32'h0, 2,
                          32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0, 3, 2, 0));
        vecs.push_back(mk(0, DM_HALF,   32'h0000_2002, 32'h0, 32'h8001_1234, 1,
                          32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_8001, 2, 1, 0));
        vecs.push_back(mk(0, DM_HALF_U, 32'h0000_2002, 32'h0, 32'h8001_1234, 1,
                          32'h0000_2000, 4'b1100, 32'h0, 32'h0000_8001, 2, 1, 0));
        vecs.push_back(mk(0, DM_BYTE,   32'h0000_4001, 32'h0, 32'h1122_8033, 3,
                          32'h0000_4000, 4'b0010, 32'h0, 32'hFFFF_FF80, 4, 3, 0));
        vecs.push_back(mk(0, DM_BYTE_U, 32'h0000_4002, 32'h0, 32'h1122_8033, 1,
                          32'h0000_4000, 4'b0100, 32'h0, 32'h0000_0022, 2, 1, 0));
        vecs.push_back(mk(0, DM_WORD,   32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 1,
                          32'h0000_5000, 4'b1111, 32'h0, 32'hDEAD_BEEF, 2, 1, 0));
        vecs.push_back(mk(1, DM_HALF,   32'h0000_6002, 32'hFFFF_BEEF, 32'h0, 1,
                          32'h0000_6000, 4'b1100, 32'hBEEF_BEEF, 32'h0, 2, 1, 0));
        vecs.push_back(mk(1, DM_WORD,   32'h0000_7004, 32'h1234_5678, 32'h0, 1,
                          32'h0000_7004, 4'b1111, 32'h1234_5678, 32'h0, 2, 1, 0));
        vecs.push_back(mk(0, 3'd7,      32'h0000_8000, 32'h0, 32'hCAFE_F00D, 2,
                          32'h0000_8000, 4'b1111, 32'h0, 32'hCAFE_F00D, 3, 2, 0));
        vecs.push_back(mk(1, DM_BYTE_U, 32'h0000_9000, 32'h1234_56C3, 32'h0, 1,
                          32'h0000_9000, 4'b0001, 32'hC3C3_C3C3, 32'h0, 2, 1, 0));
`ifdef DM_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, DM_WORD,   32'h0000_3001, 32'h0, 32'h55AA_55AA, 1,
                          32'h0, 4'h0, 32'h0, 32'h0, 1, 0, 1));
        vecs.push_back(mk(0, DM_HALF_U, 32'h0000_3003, 32'h0, 32'hABCD_0000, 1,
                          32'h0, 4'h0, 32'h0, 32'h0, 1, 0, 1));
`else
        vecs.push_back(mk(0, DM_WORD,   32'h0000_3001, 32'h0, 32'h55AA_55AA, 1,
                          32'h0000_3000, 4'b1111, 32'h0, 32'h55AA_55AA, 2, 1, 0));
        vecs.push_back(mk(0, DM_HALF_U, 32'h0000_3003, 32'h0, 32'hABCD_0000, 1,
                          32'h0000_3000, 4'b1100, 32'h0, 32'h0000_ABCD, 2, 1, 0));
`endif
        vecs.push_back(mk(0, DM_WORD,   32'h0000_A000, 32'h0, 32'hFFFF_FFFF, 0,
                          32'h0000_A000, 4'b1111, 32'h0, 32'h0, 16, 15, 1));
        vecs.push_back(mk(0, DM_WORD,   32'h0000_B000, 32'h0, 32'h0F0F_0F0F, 15,
                          32'h0000_B000, 4'b1111, 32'h0, 32'h0F0F_0F0F, 16, 15, 0));
        vecs.push_back(mk(0, DM_WORD,   32'h0000_C000, 32'h0, 32'h1357_9BDF, 1,
                          32'h0000_C000, 4'b1111, 32'h0, 32'h1357_9BDF, 2, 1, 0));

        // Reset with a live request on the pins: everything must read zero.
        rst           = 1'b0;
        bif.mem_req   = 1'b1;
        bif.mem_w     = 1'b1;
        bif.addr      = 32'h0000_1234;
        bif.wdata     = 32'hFFFF_FFFF;
        bif.dm_type   = DM_WORD;
        bif.bus_ready = 1'b1;
        bif.bus_rdata = 32'hFFFF_FFFF;
        #12;
        chk("reset stall", 32'(bif.stall), 32'd0);
        chk("reset err", 32'(bif.err), 32'd0);
        chk("reset bus_req", 32'(bif.bus_req), 32'd0);
        chk("reset bus_we", 32'(bif.bus_we), 32'd0);
        chk("reset bus_be", 32'(bif.bus_be), 32'd0);
        chk("reset bus_addr", bif.bus_addr, 32'h0);
        chk("reset bus_wdata", bif.bus_wdata, 32'h0);
        chk("reset rdata", bif.rdata, 32'h0);
        @(posedge clk);
        #1;
        bif.mem_req   = 1'b0;
        bif.bus_ready = 1'b0;
        rst           = 1'b1;

        // Back-to-back: each access is driven on the cycle right after the previous DONE.
        for (int i = 0; i < vecs.size(); i++) run_access(vecs[i], i);

        // bus_ready while IDLE must not start or finish anything.
        bif.bus_ready = 1'b1;
        bif.bus_rdata = 32'hFFFF_FFFF;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bif.stall !== 1'b0 || bif.bus_req !== 1'b0 || bif.rdata !== 32'h0 || bif.err !== 1'b0)
                bad++;
            @(posedge clk);
            #1;
        end
        chk("idle bus_ready ignored", 32'(bad), 32'd0);
        bif.bus_ready = 1'b0;

        // Reset asserted on the 3rd WAIT cycle of a load with mem_req still held.
        bif.mem_req = 1'b1;
        bif.mem_w   = 1'b0;
        bif.addr    = 32'h0000_D000;
        bif.dm_type = DM_WORD;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midwait bus_req before reset", 32'(bif.bus_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("midwait reset bus_req", 32'(bif.bus_req), 32'd0);
        chk("midwait reset stall", 32'(bif.stall), 32'd0);
        chk("midwait reset bus_addr", bif.bus_addr, 32'h0);
        chk("midwait reset err", 32'(bif.err), 32'd0);
        @(negedge clk);
        bif.mem_req = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #1;
        run_access(mk(0, DM_BYTE_U, 32'h0000_E003, 32'h0, 32'h9A00_0000, 1,
                      32'h0000_E000, 4'b1000, 32'h0, 32'h0000_009A, 2, 1, 0), 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
